// File: rtl/spike_event_encoder.sv
// AER spike encoder: pending-spike register, lowest-index-first arbiter, event FIFO and saturating drop counter.
// Optional timestamp counter and FIFO timestamp field enabled by `define SPIKE_TIMESTAMP_EN.
module spike_event_encoder #(
  parameter int N_NEURONS  = 4,
  parameter int ADDR_W     = 2,
  parameter int TS_W       = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_NEURONS-1:0]            spike_in,
  input  logic                            ts_tick,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [ADDR_W-1:0]               out_addr,
  output logic [TS_W-1:0]                 out_ts,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic [7:0]                      drop_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  function automatic logic [7:0] popcount(input logic [N_NEURONS-1:0] v);
    logic [7:0] c;
    c = 8'd0;
    for (int i = 0; i < N_NEURONS; i++) begin
      c = c + 8'(v[i]);
    end
    return c;
  endfunction

  function automatic logic [ADDR_W-1:0] lowest_index(input logic [N_NEURONS-1:0] v);
    logic [ADDR_W-1:0] idx;
    idx = '0;
    for (int i = N_NEURONS - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = ADDR_W'(i);
      end
    end
    return idx;
  endfunction

  logic [N_NEURONS-1:0] pending_r;
  logic [CNT_W-1:0]     count_r;
  logic                 full_r;
  logic                 valid_r;
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [7:0]           drop_r;
  logic [ADDR_W-1:0]    addr_mem_r [FIFO_DEPTH];

  logic [N_NEURONS-1:0] grant_s;
  logic [ADDR_W-1:0]    grant_idx_s;
  logic                 push_s;
  logic                 pop_s;
  logic [N_NEURONS-1:0] drops_s;
  logic [8:0]           drop_sum_s;
  logic [7:0]           drop_next_s;
  logic [CNT_W-1:0]     count_next_s;

  // Arbitration uses the registered full flag, so a same-cycle pop never frees a slot for a push.
  always_comb begin
    grant_s     = '0;
    grant_idx_s = lowest_index(pending_r);
    if ((pending_r != '0) && !full_r) begin
      grant_s = pending_r & (~pending_r + N_NEURONS'(1));
    end else begin
      grant_s = '0;
    end
    push_s = |grant_s;
    pop_s  = valid_r && out_ready;
  end

  // A spike landing on a still-pending, ungranted neuron is merged and counted as a drop.
  always_comb begin
    drops_s     = spike_in & pending_r & ~grant_s;
    drop_sum_s  = {1'b0, drop_r} + {1'b0, popcount(drops_s)};
    drop_next_s = drop_sum_s[8] ? 8'hFF : drop_sum_s[7:0];
  end

  // Occupancy after this edge's push/pop.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Control state: pending set wins over grant clear, pointers, flags and drop counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_r <= '0;
      count_r   <= '0;
      full_r    <= 1'b0;
      valid_r   <= 1'b0;
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      drop_r    <= 8'd0;
    end else begin
      pending_r <= (pending_r & ~grant_s) | spike_in;
      count_r   <= count_next_s;
      full_r    <= (count_next_s == CNT_W'(FIFO_DEPTH));
      valid_r   <= (count_next_s != '0);
      drop_r    <= drop_next_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
    end
  end

  // Address storage; cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        addr_mem_r[i] <= '0;
      end
    end else if (push_s) begin
      addr_mem_r[wr_ptr_r] <= grant_idx_s;
    end
  end

  assign out_valid  = valid_r;
  assign out_addr   = addr_mem_r[rd_ptr_r];
  assign fifo_count = count_r;
  assign drop_count = drop_r;

`ifdef SPIKE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_r;
  logic [TS_W-1:0] ts_mem_r [FIFO_DEPTH];

  // Timestamp counter; the pushed stamp is the value before this edge's increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_r <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        ts_mem_r[i] <= '0;
      end
    end else begin
      if (ts_tick) begin
        ts_r <= ts_r + TS_W'(1);
      end
      if (push_s) begin
        ts_mem_r[wr_ptr_r] <= ts_r;
      end
    end
  end

  assign out_ts = ts_mem_r[rd_ptr_r];
`else
  logic unused_ts_tick_s;
  assign unused_ts_tick_s = ts_tick;
  assign out_ts = '0;
`endif

endmodule

// File: tb/tb_spike_event_encoder.sv
// Scoreboard bench for spike_event_encoder: an event-level model pushes expected events,
// a negedge monitor compares the FIFO head, occupancy and drop counter.
module tb_spike_event_encoder;
  localparam int N     = 4;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] spike_in = 4'd0;
  logic       ts_tick = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [1:0] out_addr;
  logic [7:0] out_ts;
  logic [3:0] fifo_count;
  logic [7:0] drop_count;

  spike_event_encoder #(.N_NEURONS(4), .ADDR_W(2), .TS_W(8), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .spike_in(spike_in), .ts_tick(ts_tick),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_ts(out_ts), .fifo_count(fifo_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {int addr; int ts;} ev_t;
  ev_t exp_q[$];
  bit  pend [N];
  int  mcount, mdrop, mts;
  bit  fresh;
  bit  chk_en = 1'b0;
  int  tests = 0;
  int  fails = 0;

`ifdef SPIKE_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT state with the model and retires the head on each handshake.
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", int'(out_valid), int'(mcount != 0));
      check("fifo_count", int'(fifo_count), mcount);
      check("drop_count", int'(drop_count), mdrop);
      if (fresh && !out_valid) begin
        check("idle_addr", int'(out_addr), 0);
        check("idle_ts", int'(out_ts), 0);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", 1, 0);
        end else begin
          check("out_addr", int'(out_addr), exp_q[0].addr);
          check("out_ts", int'(out_ts), exp_q[0].ts);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic model_clear();
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    mcount = 0;
    mdrop  = 0;
    mts    = 0;
    fresh  = 1'b1;
    exp_q.delete();
  endtask

  // Event-level reference: one arbitration decision per clock edge.
  task automatic model_edge(input logic [3:0] s, input bit t, input bit r);
    int  g;
    bit  pop;
    ev_t ev;
    g = -1;
    if (mcount < DEPTH) begin
      for (int i = 0; i < N; i++) if (pend[i] && g < 0) g = i;
    end
    for (int i = 0; i < N; i++) begin
      if (s[i] && pend[i] && i != g) mdrop = (mdrop < 255) ? mdrop + 1 : 255;
    end
    if (g >= 0) begin
      ev.addr = g;
      ev.ts   = TS_EN ? mts : 0;
      exp_q.push_back(ev);
      pend[g] = 1'b0;
      fresh   = 1'b0;
    end
    for (int i = 0; i < N; i++) if (s[i]) pend[i] = 1'b1;
    pop = (mcount > 0) && r;
    mcount = mcount + ((g >= 0) ? 1 : 0) - (pop ? 1 : 0);
    if (t) mts = (mts + 1) % 256;
  endtask

  task automatic step(input logic [3:0] s, input bit t, input bit r);
    spike_in  = s;
    ts_tick   = t;
    out_ready = r;
    @(negedge clk);
    #1;
    model_edge(s, t, r);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    chk_en    = 1'b0;
    spike_in  = 4'd0;
    ts_tick   = 1'b0;
    @(negedge clk);
    #1;
    @(posedge clk);
    #1;
    model_clear();
    rst_n  = 1'b1;
    chk_en = 1'b1;
  endtask

  initial begin
    model_clear();
    do_reset();
    repeat (10) step(4'd0, 1'b0, 1'b1);

    step(4'b0100, 1'b0, 1'b1);
    repeat (5) step(4'd0, 1'b0, 1'b1);

    do_reset();
    step(4'b1011, 1'b1, 1'b1);
    repeat (8) step(4'd0, 1'b1, 1'b1);

    // Same neuron spiking while its grant is issued stays pending.
    step(4'b0001, 1'b0, 1'b1);
    step(4'b0001, 1'b0, 1'b1);
    repeat (5) step(4'd0, 1'b0, 1'b1);

    do_reset();
    for (int i = 0; i < 8; i++) step(4'(1 << (i % 4)), 1'b1, 1'b0);
    repeat (3) step(4'd0, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    step(4'd0, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    repeat (3) step(4'd0, 1'b0, 1'b0);
    repeat (14) step(4'd0, 1'b0, 1'b1);

    do_reset();
    repeat (255) step(4'd0, 1'b1, 1'b1);
    step(4'b0001, 1'b0, 1'b1);
    step(4'd0, 1'b0, 1'b1);
    step(4'd0, 1'b1, 1'b1);
    step(4'b0001, 1'b0, 1'b1);
    repeat (5) step(4'd0, 1'b0, 1'b1);

    // Five buffered, two pending, then reset.
    do_reset();
    step(4'b1111, 1'b0, 1'b0);
    step(4'd0, 1'b0, 1'b0);
    step(4'd0, 1'b0, 1'b0);
    step(4'b0011, 1'b0, 1'b0);
    step(4'd0, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    do_reset();
    repeat (6) step(4'd0, 1'b0, 1'b1);

    // Drop counter saturation with the FIFO held full.
    do_reset();
    repeat (110) step(4'b1111, 1'b1, 1'b0);
    repeat (16) step(4'd0, 1'b0, 1'b1);

    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step(4'($urandom_range(0, 15) & $urandom_range(0, 15)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
      end
    end
    repeat (20) step(4'd0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spike_event_encoder.md
Name: spike_event_encoder

Overview:
- Downstream stage of the LIF neuron array: takes per-neuron spike pulses and turns them into a buffered address-event (AER) stream.
- Each event carries the neuron index and a timestep stamp. Events leave through a valid/ready interface toward the router/host link.
- Contains a pending-spike register, a fixed-priority arbiter, a timestep counter, an event FIFO and a saturating drop counter.

Parameters:
- N_NEURONS, 4, number of spike inputs (1..16)
- ADDR_W, 2, neuron address width; 2**ADDR_W >= N_NEURONS required
- TS_W, 8, timestamp width
- FIFO_DEPTH, 8, event FIFO entries; power of two, >= 2

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- spike_in  in  N_NEURONS  one-cycle spike pulses from LIF neurons, bit i = neuron i
- ts_tick  in  1  timestep strobe; advances the timestamp counter
- out_valid  out  1  FIFO head holds an event
- out_ready  in  1  consumer accepts the head event
- out_addr  out  ADDR_W  neuron index of the head event
- out_ts  out  TS_W  timestamp of the head event
- fifo_count  out  clog2(FIFO_DEPTH)+1  occupied entries
- drop_count  out  8  saturating count of merged/lost spikes

Behaviour:
- Reset (rst_n low at a clk edge):
  - pending, ts counter, FIFO pointers and drop_count cleared.
  - out_valid=0, out_addr=0, out_ts=0, fifo_count=0, drop_count=0.
  - Reset mid-stream discards all buffered and pending events; no partial event appears afterwards.
- Pending register: each edge, pending_next = (pending & ~grant) | spike_in.
  - If set and clear hit the same bit in one cycle, set wins and the spike stays pending.
- Drop: spike_in[i]=1 while pending[i]=1 and grant[i]=0 → drop_count += 1 per such bit, saturating at 255.
  - Multiple drops in one cycle add their popcount, clipped at 255.
- Arbiter: fixed priority, lowest index wins. Grant is issued only when pending != 0 and the FIFO is not full.
  - At most one grant/push per cycle.
  - No grant while full; pending bits are held.
- Push: at the grant edge, the FIFO writes {index, ts} using the ts counter value before any increment on that edge.
- Timestamp counter: +1 at each edge with ts_tick=1; wraps from 2**TS_W-1 to 0.
- Pop: at an edge with out_valid && out_ready.
  - Push and pop on the same edge are both honoured; fifo_count is unchanged.
  - Pop on empty is ignored.
  - A full FIFO blocks push even if a pop occurs that cycle (the grant uses the registered full flag).
- Outputs: out_addr/out_ts are driven from FIFO head storage; they hold 0 when empty after reset.
  - Head must stay stable while out_valid && !out_ready.
- Latency: spike_in high in cycle 0 with pending and FIFO empty → pending set at edge 1, pushed at edge 2 → out_valid=1 in cycle 2.
- fifo_count: registered, exact occupancy, 0..FIFO_DEPTH.

Optional Feature:
- Macro SPIKE_TIMESTAMP_EN.
- Defined: behaviour as above; timestamp counter and TS_W-wide FIFO field are present.
- Undefined: no counter and no timestamp storage; out_ts tied to 0; ts_tick ignored; FIFO stores addresses only. All other timing is identical.

Test Plan:
- Reset then idle 10 cycles, out_ready=1 → out_valid=0, fifo_count=0, drop_count=0 throughout.
- Single spike_in=4'b0100 in cycle 0, ts counter=0 → out_valid=1 in cycle 2 with out_addr=2, out_ts=0; popped at the next edge, fifo_count returns to 0.
- spike_in=4'b1011 in one cycle, out_ready=1, ts_tick=1 every cycle from reset → events out in order addr 0, 1, 3, with consecutive pushes and out_ts differing by 1 each; drop_count=0.
- out_ready=0, spike each neuron in turn until 8 events are buffered, then spike neuron 0 twice more → fifo_count=8; pending[0] held; second pulse increments drop_count to 1; after out_ready=1, 9 events total drain.
- Timestamp wrap: 255 ts_tick pulses, then a spike, then ts_tick, then a spike → out_ts=255 then 0 (macro defined); out_ts=0 for both (macro undefined).
- Reset asserted with 5 events buffered and 2 pending → next cycle out_valid=0, fifo_count=0; no stale events after release.
